regression_normal_accum: RTL and testbench

//  Streams per-path samples for one LSM exercise date and accumulates the 3x3 normal equations
//  A = sum(phi*phi^T) and B = sum(phi*y) over basis phi = [1, x, x^2], counting in-the-money paths only.
//  On batch end, emits A_flat[0:8] and B_flat[0:2] in Q16.16 with a one-cycle valid pulse.
//  It feeds the 3x3 Gaussian-elimination regression stage directly, which has no backpressure.

---
 rtl/regression_normal_accum_pkg.sv | 35 +++
 rtl/regression_normal_accum_arith.sv | 93 +++++++++
 rtl/regression_normal_accum.sv | 193 +++++++++++++++++++
 tb/tb_regression_normal_accum.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regression_normal_accum_pkg.sv
// Shared configuration for the LSM normal-equation accumulator: fixed-point
// format, multiplier depth, accumulator guard bits, FSM states and sum indices.
package regression_normal_accum_pkg;

  localparam int FP_WIDTH       = 32;
  localparam int FP_QINT        = 16;
  localparam int FP_QFRAC       = 16;
  localparam int FP_MUL_LATENCY = 2;
  localparam int ACC_GUARD_BITS = 16;

  typedef enum logic [1:0] {ACC, DRAIN, EMIT} nacc_state_t;

  // Tags travelling alongside each sample through the product pipeline.
  typedef struct packed {
    logic valid;
    logic itm;
    logic last;
  } tag_t;

  // Running sums kept by the accumulator bank.
  localparam int N_SUMS   = 7;
  localparam int IDX_SX   = 0;
  localparam int IDX_SX2  = 1;
  localparam int IDX_SX3  = 2;
  localparam int IDX_SX4  = 3;
  localparam int IDX_SY   = 4;
  localparam int IDX_SXY  = 5;
  localparam int IDX_SX2Y = 6;

  // Cycles spent in DRAIN between accepting the last sample and EMIT.
  function automatic int drain_cycles(input int mul_latency);
    return 2 * mul_latency + 2;
  endfunction

endpackage

// File: rtl/regression_normal_accum_arith.sv
// Arithmetic building blocks: register delay line, pipelined truncating
// fixed-point multiplier, and the guard-bit saturating accumulator.

module fx_delay #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] pipe [DEPTH];

  // Plain shift register, DEPTH stages deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];
endmodule

module fx_mul #(
  parameter int WIDTH   = 32,
  parameter int QFRAC   = 16,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);
  localparam int PW = 2 * WIDTH;

  logic signed [PW-1:0]    a_w, b_w, prod;
  logic        [WIDTH-1:0] prod_trunc;

  // Full-width signed product; the arithmetic shift floors toward -inf and the
  // upper bits are simply dropped (callers keep |x| small enough).
  assign a_w        = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_w        = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod       = a_w * b_w;
  assign prod_trunc = WIDTH'(prod >>> QFRAC);

  fx_delay #(.WIDTH(WIDTH), .DEPTH(LATENCY)) u_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (prod_trunc),
    .dout (p)
  );
endmodule

module fx_sat_acc #(
  parameter int WIDTH = 32,
  parameter int GUARD = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout,
  output logic                    ovf
);
  localparam int AW = WIDTH + GUARD;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] din_ext;

  assign din_ext = {{GUARD{din[WIDTH-1]}}, din};

  // Wide accumulator; clear wins over a same-cycle add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + din_ext;
  end

  // Fits in WIDTH only when every bit above the WIDTH sign bit matches it.
  assign ovf = !((&acc[AW-1:WIDTH-1]) || !(|acc[AW-1:WIDTH-1]));

  // Saturating read-out toward the sign of the wide sum.
  always_comb begin
    dout = acc[WIDTH-1:0];
    if (ovf) dout = acc[AW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
endmodule

// File: rtl/regression_normal_accum.sv
// Streams per-path (x, y) samples, forms basis products through two multiplier
// stages and accumulates the 3x3 normal matrix and right-hand side over the
// in-the-money paths of one batch, emitting them with a one-cycle valid pulse.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ACC   | accepting samples, ready_in high
//   DRAIN | last sample accepted; waiting for it to clear the pipeline
//   EMIT  | register outputs, pulse valid_out, clear sums and count
module regression_normal_accum
  import regression_normal_accum_pkg::*;
#(
  parameter int WIDTH       = FP_WIDTH,
  parameter int QINT        = FP_QINT,
  parameter int QFRAC       = FP_QFRAC,
  parameter int MUL_LATENCY = FP_MUL_LATENCY,
  parameter int ACC_GUARD   = ACC_GUARD_BITS,
  parameter int MIN_PATHS   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             last_in,
  input  logic             itm_in,
  input  logic [WIDTH-1:0] s_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] A_flat [9],
  output logic [WIDTH-1:0] B_flat [3],
  output logic [15:0]      n_paths,
  output logic             degenerate,
  output logic             sat
);
  localparam int                 DRAIN_TC_I = drain_cycles(MUL_LATENCY) - 1;
  localparam int                 DRAIN_W    = $clog2(DRAIN_TC_I + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_TC   = DRAIN_W'(DRAIN_TC_I);
  localparam logic [15:0]        CNT_MAX    = 16'((1 << QINT) - 1);
  localparam logic [15:0]        CNT_A0_LIM = 16'(1 << (WIDTH - 1 - QFRAC));
  localparam logic [WIDTH-1:0]   FX_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam int                 S1_W       = 2 * WIDTH + 3;
  localparam int                 S2_W       = 4 * WIDTH + 3;

  nacc_state_t        state, state_nxt;
  logic               accept, emit, acc_en;
  tag_t               tag_in, tag_s1, tag_s2;
  logic [WIDTH-1:0]   x2_s1, xy_s1, x_s1, y_s1;
  logic [WIDTH-1:0]   x3_s2, x4_s2, x2y_s2, x_s2, y_s2, x2_s2, xy_s2;
  logic [S1_W-1:0]    s1_din, s1_dout;
  logic [S2_W-1:0]    s2_din, s2_dout;
  logic [WIDTH-1:0]   acc_din [N_SUMS];
  logic [WIDTH-1:0]   sum_q   [N_SUMS];
  logic [N_SUMS-1:0]  sum_ovf;
  logic [15:0]        cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               last_seen;
  logic               cnt_ovf;
  logic [16+QFRAC-1:0] cnt_fx;
  logic [WIDTH-1:0]   a0;

  assign accept = valid_in & ready_in;
  assign tag_in = {accept, itm_in, last_in};

  // Stage 1: x^2 and x*y, with x, y and tags delay-matched.
  fx_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC), .LATENCY(MUL_LATENCY)) u_mul_x2 (
    .clk(clk), .rst_n(rst_n), .a(s_in), .b(s_in), .p(x2_s1));
  fx_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC), .LATENCY(MUL_LATENCY)) u_mul_xy (
    .clk(clk), .rst_n(rst_n), .a(s_in), .b(y_in), .p(xy_s1));

  assign s1_din = {tag_in, s_in, y_in};
  fx_delay #(.WIDTH(S1_W), .DEPTH(MUL_LATENCY)) u_dly_s1 (
    .clk(clk), .rst_n(rst_n), .din(s1_din), .dout(s1_dout));
  assign {tag_s1, x_s1, y_s1} = s1_dout;

  // Stage 2: x^3, x^4, x^2*y; stage-1 values ride along.
  fx_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC), .LATENCY(MUL_LATENCY)) u_mul_x3 (
    .clk(clk), .rst_n(rst_n), .a(x2_s1), .b(x_s1), .p(x3_s2));
  fx_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC), .LATENCY(MUL_LATENCY)) u_mul_x4 (
    .clk(clk), .rst_n(rst_n), .a(x2_s1), .b(x2_s1), .p(x4_s2));
  fx_mul #(.WIDTH(WIDTH), .QFRAC(QFRAC), .LATENCY(MUL_LATENCY)) u_mul_x2y (
    .clk(clk), .rst_n(rst_n), .a(x2_s1), .b(y_s1), .p(x2y_s2));

  assign s2_din = {tag_s1, x_s1, y_s1, x2_s1, xy_s1};
  fx_delay #(.WIDTH(S2_W), .DEPTH(MUL_LATENCY)) u_dly_s2 (
    .clk(clk), .rst_n(rst_n), .din(s2_din), .dout(s2_dout));
  assign {tag_s2, x_s2, y_s2, x2_s2, xy_s2} = s2_dout;

  // Stage 3: accumulate in-the-money samples.
  assign acc_en            = tag_s2.valid & tag_s2.itm;
  assign acc_din[IDX_SX]   = x_s2;
  assign acc_din[IDX_SX2]  = x2_s2;
  assign acc_din[IDX_SX3]  = x3_s2;
  assign acc_din[IDX_SX4]  = x4_s2;
  assign acc_din[IDX_SY]   = y_s2;
  assign acc_din[IDX_SXY]  = xy_s2;
  assign acc_din[IDX_SX2Y] = x2y_s2;

  for (genvar g = 0; g < N_SUMS; g++) begin : g_sum
    fx_sat_acc #(.WIDTH(WIDTH), .GUARD(ACC_GUARD)) u_acc (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (emit),
      .en   (acc_en),
      .din  (acc_din[g]),
      .dout (sum_q[g]),
      .ovf  (sum_ovf[g])
    );
  end

  // ITM path counter, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        cnt <= '0;
    else if (emit)                     cnt <= '0;
    else if (acc_en && cnt != CNT_MAX) cnt <= cnt + 16'd1;
  end

  // Drain timer: loaded when the closing sample is accepted, counts to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                drain_cnt <= '0;
    else if (state == ACC && accept && last_in) drain_cnt <= DRAIN_TC;
    else if (state == DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DRAIN_W'(1);
  end

  // Interlock: the tagged-last sample must actually have been accumulated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          last_seen <= 1'b0;
    else if (emit)                       last_seen <= 1'b0;
    else if (tag_s2.valid && tag_s2.last) last_seen <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  // Next-state and control decode.
  always_comb begin
    state_nxt = state;
    ready_in  = 1'b0;
    emit      = 1'b0;
    case (state)
      ACC: begin
        ready_in = 1'b1;
        if (valid_in && last_in) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == '0 && last_seen) state_nxt = EMIT;
      end
      EMIT: begin
        emit      = 1'b1;
        state_nxt = ACC;
      end
      default: state_nxt = ACC;
    endcase
  end

  // Path count as a Q-format value, clamped when it exceeds the integer range.
  assign cnt_fx  = {cnt, {QFRAC{1'b0}}};
  assign cnt_ovf = (cnt >= CNT_A0_LIM);
  assign a0      = cnt_ovf ? FX_MAX : WIDTH'(cnt_fx);

  // Output registers, loaded only in EMIT and held until the next EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      for (int i = 0; i < 9; i++) A_flat[i] <= '0;
      for (int i = 0; i < 3; i++) B_flat[i] <= '0;
      n_paths    <= '0;
      degenerate <= 1'b0;
      sat        <= 1'b0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        A_flat[0]  <= a0;
        A_flat[1]  <= sum_q[IDX_SX];
        A_flat[3]  <= sum_q[IDX_SX];
        A_flat[2]  <= sum_q[IDX_SX2];
        A_flat[4]  <= sum_q[IDX_SX2];
        A_flat[6]  <= sum_q[IDX_SX2];
        A_flat[5]  <= sum_q[IDX_SX3];
        A_flat[7]  <= sum_q[IDX_SX3];
        A_flat[8]  <= sum_q[IDX_SX4];
        B_flat[0]  <= sum_q[IDX_SY];
        B_flat[1]  <= sum_q[IDX_SXY];
        B_flat[2]  <= sum_q[IDX_SX2Y];
        n_paths    <= cnt;
        degenerate <= (cnt < 16'(MIN_PATHS));
        sat        <= cnt_ovf | (|sum_ovf);
      end
    end
  end
endmodule

// File: tb/tb_regression_normal_accum.sv
// Directed bench for regression_normal_accum: a Q16.16 reference model builds
// expected batch results, queued at the closing sample and checked at valid_out.
module tb_regression_normal_accum;
  import regression_normal_accum_pkg::*;

  localparam int L       = FP_MUL_LATENCY;
  localparam int LAT     = 2 * L + 3;
  localparam int TIMEOUT = 80;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0, last_in = 1'b0, itm_in = 1'b0;
  logic [31:0] s_in = '0, y_in = '0;
  logic        ready_in, valid_out;
  logic [31:0] A_flat [9];
  logic [31:0] B_flat [3];
  logic [15:0] n_paths;
  logic        degenerate, sat;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [8:0][31:0] a;
    logic [2:0][31:0] b;
    logic [15:0]      n;
    logic             degen;
    logic             sat;
  } exp_t;

  exp_t   sb [$];
  longint m_sx, m_sx2, m_sx3, m_sx4, m_sy, m_sxy, m_sx2y;
  int     m_cnt;
  bit     m_sat;

  regression_normal_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .itm_in    (itm_in),
    .s_in      (s_in),
    .y_in      (y_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .A_flat    (A_flat),
    .B_flat    (B_flat),
    .n_paths   (n_paths),
    .degenerate(degenerate),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fxm(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    return 32'(p >>> 16);
  endfunction

  function automatic longint sx(input logic [31:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic logic [31:0] clamp32(input longint v);
    if (v > longint'(32'sh7FFFFFFF)) begin m_sat = 1'b1; return 32'h7FFF_FFFF; end
    if (v < -longint'(64'sh80000000)) begin m_sat = 1'b1; return 32'h8000_0000; end
    return 32'(v);
  endfunction

  task automatic model_clear();
    m_sx = 0; m_sx2 = 0; m_sx3 = 0; m_sx4 = 0; m_sy = 0; m_sxy = 0; m_sx2y = 0;
    m_cnt = 0; m_sat = 1'b0;
  endtask

  task automatic model_sample(input logic itm, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] x2;
    if (itm) begin
      x2 = fxm(x, x);
      if (m_cnt < 65535) m_cnt++;
      m_sx   += sx(x);
      m_sx2  += sx(x2);
      m_sx3  += sx(fxm(x2, x));
      m_sx4  += sx(fxm(x2, x2));
      m_sy   += sx(y);
      m_sxy  += sx(fxm(x, y));
      m_sx2y += sx(fxm(x2, y));
    end
  endtask

  task automatic push_expected();
    exp_t        e;
    logic [31:0] c1, c2, c3;
    m_sat = 1'b0;
    e.a[0] = clamp32(longint'(m_cnt) <<< 16);
    c1 = clamp32(m_sx);
    c2 = clamp32(m_sx2);
    c3 = clamp32(m_sx3);
    e.a[1] = c1; e.a[3] = c1;
    e.a[2] = c2; e.a[4] = c2; e.a[6] = c2;
    e.a[5] = c3; e.a[7] = c3;
    e.a[8] = clamp32(m_sx4);
    e.b[0] = clamp32(m_sy);
    e.b[1] = clamp32(m_sxy);
    e.b[2] = clamp32(m_sx2y);
    e.n     = 16'(m_cnt);
    e.degen = (m_cnt < 3);
    e.sat   = m_sat;
    sb.push_back(e);
    model_clear();
  endtask

  // Drive one sample that the DUT is expected to accept on the next edge.
  task automatic send(input logic itm, input logic last, input int xi, input int yi);
    chk("ready_before_send", {63'd0, ready_in}, 64'd1);
    valid_in = 1'b1; last_in = last; itm_in = itm;
    s_in = 32'(xi <<< 16); y_in = 32'(yi <<< 16);
    model_sample(itm, s_in, y_in);
    if (last) push_expected();
    @(posedge clk); #1;
    valid_in = 1'b0; last_in = 1'b0; itm_in = 1'b0;
  endtask

  // Called #1 after the edge that accepted last_in.
  task automatic wait_emit(input string tag, input bit chk_rdy);
    int   lat, rdy_low;
    bit   seen;
    exp_t e;
    lat = 0; seen = 1'b0;
    rdy_low = ready_in ? 0 : 1;
    while (!seen && lat < TIMEOUT) begin
      @(posedge clk); #1;
      lat++;
      if (valid_out) seen = 1'b1;
      else if (!ready_in) rdy_low++;
    end
    valid_in = 1'b0; last_in = 1'b0; itm_in = 1'b0;
    chk({tag, "_valid_out_seen"}, {63'd0, seen}, 64'd1);
    if (!seen) return;
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    if (chk_rdy) chk({tag, "_ready_low_cycles"}, 64'(rdy_low), 64'(2 * L + 3));
    chk({tag, "_scoreboard_has_entry"}, {63'd0, sb.size() > 0}, 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < 9; i++) chk($sformatf("%s_A%0d", tag, i), {32'd0, A_flat[i]}, {32'd0, e.a[i]});
      for (int i = 0; i < 3; i++) chk($sformatf("%s_B%0d", tag, i), {32'd0, B_flat[i]}, {32'd0, e.b[i]});
      chk({tag, "_n_paths"}, {48'd0, n_paths}, {48'd0, e.n});
      chk({tag, "_degenerate"}, {63'd0, degenerate}, {63'd0, e.degen});
      chk({tag, "_sat"}, {63'd0, sat}, {63'd0, e.sat});
    end
    @(posedge clk); #1;
    chk({tag, "_pulse_one_cycle"}, {63'd0, valid_out}, 64'd0);
  endtask

  task automatic watch_no_emit(input string tag, input int cycles);
    int n_vo;
    n_vo = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (valid_out) n_vo++;
    end
    chk(tag, 64'(n_vo), 64'd0);
  endtask

  initial begin
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_in", {63'd0, ready_in}, 64'd1);
    chk("rst_valid_out", {63'd0, valid_out}, 64'd0);
    chk("rst_A0", {32'd0, A_flat[0]}, 64'd0);
    chk("rst_B2", {32'd0, B_flat[2]}, 64'd0);
    chk("rst_n_paths", {48'd0, n_paths}, 64'd0);
    chk("rst_degenerate", {63'd0, degenerate}, 64'd0);
    chk("rst_sat", {63'd0, sat}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: x = 1,2,3, y = 1
    send(1, 0, 1, 1); send(1, 0, 2, 1); send(1, 1, 3, 1);
    wait_emit("t1", 1'b1);
    chk("t1_A0_literal", {32'd0, A_flat[0]}, 64'h0003_0000);
    chk("t1_A8_literal", {32'd0, A_flat[8]}, 64'h0062_0000);
    chk("t1_A5_literal", {32'd0, A_flat[5]}, 64'h0024_0000);

    // Test 2: leading out-of-the-money x=5 is ignored
    send(0, 0, 5, 0); send(1, 0, 1, 1); send(1, 0, 2, 1); send(1, 1, 3, 1);
    wait_emit("t2", 1'b0);
    chk("t2_A8_literal", {32'd0, A_flat[8]}, 64'h0062_0000);

    // Test 3: all samples OTM, last on an OTM sample
    send(0, 0, 2, 3); send(0, 1, 4, 5);
    wait_emit("t3", 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_hold_degenerate", {63'd0, degenerate}, 64'd1);
    chk("t3_hold_A4", {32'd0, A_flat[4]}, 64'd0);

    // Test 4: valid_in held high through DRAIN/EMIT with x=7 is ignored
    send(1, 0, 1, 2); send(1, 1, 2, 2);
    valid_in = 1'b1; itm_in = 1'b1; last_in = 1'b1; s_in = 32'h0007_0000; y_in = 32'h0001_0000;
    wait_emit("t4a", 1'b1);
    send(1, 0, 2, 1); send(1, 0, 2, 1); send(1, 1, 2, 1);
    wait_emit("t4b", 1'b0);
    chk("t4b_A8_literal", {32'd0, A_flat[8]}, 64'h0030_0000);

    // Test 5: Sx4 overflows and saturates
    send(1, 0, 10, 1); send(1, 0, 10, 1); send(1, 0, 10, 1); send(1, 1, 10, 1);
    wait_emit("t5", 1'b0);
    chk("t5_A8_literal", {32'd0, A_flat[8]}, 64'h7FFF_FFFF);
    chk("t5_A0_literal", {32'd0, A_flat[0]}, 64'h0004_0000);
    chk("t5_sat_literal", {63'd0, sat}, 64'd1);

    // Test 6a: reset mid-batch discards the partial batch
    send(1, 0, 1, 1); send(1, 0, 2, 1);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    chk("t6_rst_valid_out", {63'd0, valid_out}, 64'd0);
    chk("t6_rst_ready_in", {63'd0, ready_in}, 64'd1);
    rst_n = 1'b1;
    watch_no_emit("t6_no_emit_after_abort", LAT + 6);

    // Test 6b: reset mid-DRAIN discards the batch
    send(1, 0, 1, 1); send(1, 0, 2, 1); send(1, 1, 3, 1);
    repeat (L + 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch_no_emit("t6_no_emit_after_drain_abort", LAT + 6);

    // Test 6c: fresh batch after the aborts
    send(1, 0, 1, 1); send(1, 0, 2, 1); send(1, 1, 3, 1);
    wait_emit("t6", 1'b1);
    chk("t6_A0_literal", {32'd0, A_flat[0]}, 64'h0003_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
